uart_cmd_wrapper: RTL and testbench

Knight-side end of the remote command link. Receives 2-byte UART frames from the remote controller, assembles them into a 16-bit command for the command processor, and transmits 8-bit response bytes back (e.g. 0xA5 acknowledge). Sits between the RX/TX pins of KnightsTour and the command-processing FSM, and contains its own UART receiver and transmitter.

---
 rtl/uart_cmd_wrapper.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_wrapper.sv
// rtl/uart_cmd_wrapper.sv - UART command receiver (2-byte frames) and response transmitter for the KnightsTour remote link
module uart_cmd_wrapper #(
    parameter int unsigned BAUD_DIV = 2604,
    parameter int unsigned IBYTE_TO = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy,
    output logic        frm_err
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(IBYTE_TO + 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BIT_PENULT = CW'(BAUD_DIV - 2);
    localparam logic [CW-1:0] HALF_LAST  = CW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(IBYTE_TO);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_e;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;

    // Synchronizer and edge detect
    logic       rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0] sync_vld_q;
    logic       rx_fall;

    // Receiver
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            frm_err_q, frm_err_d;
    logic            rx_byte_vld;
    logic            rx_busy;

    // Command assembly
    asm_state_e      asm_q, asm_d;
    logic [7:0]      hi_byte_q, hi_byte_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [15:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;

    // Transmitter
    tx_state_e       tx_state_q, tx_state_d;
    logic [9:0]      tx_shift_q, tx_shift_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic            tx_q, tx_d;
    logic            resp_sent_q, resp_sent_d;

    // Two-flop synchronizer preset idle-high; the validity pipe keeps the preset from posing as a real high level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            sync_vld_q <= 2'b00;
            rx_prev_q  <= 1'b0;
        end else begin
            rx_meta_q  <= RX;
            rx_sync_q  <= rx_meta_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            rx_prev_q  <= sync_vld_q[1] & rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_sync_q;
    assign rx_busy = (rx_state_q != RX_IDLE);

    // Receiver state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            frm_err_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            frm_err_q  <= frm_err_d;
        end
    end

    // Receiver next state: mid-bit sampling, false-start rejection, stop-bit check
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = '0;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        frm_err_d   = 1'b0;
        rx_byte_vld = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    rx_bit_d   = 3'd0;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        rx_byte_vld = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Assembly state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q     <= WAIT_HI;
            hi_byte_q <= '0;
            to_cnt_q  <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            hi_byte_q <= hi_byte_d;
            to_cnt_q  <= to_cnt_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    // Assembly next state: pair bytes, drop a stale high byte on inter-byte timeout, set beats clear
    always_comb begin
        asm_d     = asm_q;
        hi_byte_d = hi_byte_q;
        to_cnt_d  = to_cnt_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        case (asm_q)
            WAIT_HI: begin
                if (rx_byte_vld) begin
                    hi_byte_d = rx_shift_q;
                    to_cnt_d  = '0;
                    cmd_rdy_d = 1'b0;
                    asm_d     = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (rx_byte_vld) begin
                    cmd_d     = {hi_byte_q, rx_shift_q};
                    cmd_rdy_d = 1'b1;
                    asm_d     = WAIT_HI;
                end else if (!rx_busy && !rx_fall) begin
                    if (to_cnt_q == TO_LAST) begin
                        hi_byte_d = '0;
                        to_cnt_d  = '0;
                        asm_d     = WAIT_HI;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            default: asm_d = WAIT_HI;
        endcase
    end

    // Transmitter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_shift_q  <= '1;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_q        <= tx_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    // Transmitter next state: registered line output, resp_sent raised one clk early so it lands on the last stop clk
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_d        = tx_q;
        resp_sent_d = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (send_resp) begin
                    tx_state_d = TX_SHIFT;
                    tx_shift_d = {1'b1, resp, 1'b0};
                    tx_cnt_d   = '0;
                    tx_bit_d   = 4'd0;
                    tx_d       = 1'b0;
                end
            end
            TX_SHIFT: begin
                if (tx_bit_q == 4'd9 && tx_cnt_q == BIT_PENULT) begin
                    resp_sent_d = 1'b1;
                end
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_state_d = TX_IDLE;
                        tx_d       = 1'b1;
                    end else begin
                        tx_shift_d = {1'b1, tx_shift_q[9:1]};
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign TX        = tx_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;
    assign tx_busy   = (tx_state_q == TX_SHIFT);
    assign frm_err   = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb/tb_uart_cmd_wrapper.sv - self-checking bench for uart_cmd_wrapper
`timescale 1ns/1ps
module tb_uart_cmd_wrapper;
    localparam int B  = 16;
    localparam int TO = 300;

    logic        clk = 1'b0;
    logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent, tx_busy, frm_err;
    logic [15:0] cmd;
    logic [7:0]  resp;

    int n_cmp = 0;
    int n_bad = 0;
    int frm_cnt = 0;
    bit saw_4b57 = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_wrapper #(.BAUD_DIV(B), .IBYTE_TO(TO)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .resp_sent(resp_sent), .tx_busy(tx_busy), .frm_err(frm_err)
    );

    always @(posedge clk) begin
        if (frm_err === 1'b1) frm_cnt <= frm_cnt + 1;
        if (cmd_rdy === 1'b1 && cmd === 16'h4B57) saw_4b57 <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = stop;
        repeat (B) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic tx_frame(input logic [7:0] r, input bit poke);
        int errs;
        int rs_n;
        int rs_at;
        logic [9:0] frame;
        errs  = 0;
        rs_n  = 0;
        rs_at = -1;
        frame = {1'b1, r, 1'b0};
        resp = r;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        for (int k = 0; k < 10 * B; k++) begin
            if (TX !== frame[k / B]) errs++;
            if (tx_busy !== 1'b1) errs++;
            if (resp_sent === 1'b1) begin
                rs_n++;
                rs_at = k;
            end
            if (poke && k == 4 * B + 3) begin
                resp = ~r;
                send_resp = 1'b1;
            end else if (poke && k == 4 * B + 4) begin
                send_resp = 1'b0;
            end
            @(negedge clk);
        end
        check("tx_bit_errors", errs, 0);
        check("resp_sent_count", rs_n, 1);
        check("resp_sent_offset", rs_at, 10 * B - 1);
        check("tx_busy_after", tx_busy, 1'b0);
        check("tx_idle_after", TX, 1'b1);
        resp = r;
    endtask

    logic [7:0]  b, pend;
    logic [15:0] exp_cmd;
    logic        exp_rdy;
    bit          good, long_gap, prev_bad, pend_v, pend_bad, got;
    int          gap, exp_frm, fr0, lat;

    initial begin
        rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0;
        idle(3);
        check("rst_TX", TX, 1'b1);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_cmd_rdy", cmd_rdy, 1'b0);
        check("rst_resp_sent", resp_sent, 1'b0);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_frm_err", frm_err, 1'b0);
        rst = 1'b0;
        idle(5);

        // 0x4B, 0xF1 back to back with latency measurement
        got = 1'b0; lat = 0;
        fork
            begin
                uart_send(8'h4B, 1'b1);
                uart_send(8'hF1, 1'b1);
            end
            begin
                for (int n = 1; n <= 25 * B && !got; n++) begin
                    @(negedge clk);
                    if (cmd_rdy === 1'b1) begin
                        got = 1'b1;
                        lat = n;
                    end
                end
            end
        join
        check("first_cmd_seen", got, 1'b1);
        check("first_cmd_latency_ok", (lat >= 19 * B + B / 2 + 1 && lat <= 19 * B + B / 2 + 5), 1'b1);
        check("first_cmd", cmd, 16'h4BF1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("clr_cmd_rdy", cmd_rdy, 1'b0);
        check("cmd_held", cmd, 16'h4BF1);

        // response 0xA5 with an ignored mid-frame request
        tx_frame(8'hA5, 1'b1);

        // framing error, then a good pair
        fr0 = frm_cnt;
        uart_send(8'h57, 1'b0);
        idle(B);
        uart_send(8'h57, 1'b1);
        uart_send(8'hF2, 1'b1);
        idle(2);
        check("frm_err_pulses", frm_cnt - fr0, 1);
        check("cmd_after_frm", cmd, 16'h57F2);
        check("rdy_after_frm", cmd_rdy, 1'b1);

        // inter-byte timeout drops a lone high byte
        uart_send(8'h4B, 1'b1);
        idle(1);
        check("hi_clears_rdy", cmd_rdy, 1'b0);
        check("hi_keeps_cmd", cmd, 16'h57F2);
        idle(TO + 100);
        uart_send(8'h57, 1'b1);
        uart_send(8'hF2, 1'b1);
        idle(1);
        check("cmd_after_timeout", cmd, 16'h57F2);
        check("rdy_after_timeout", cmd_rdy, 1'b1);

        // randomized byte stream against a pairing model
        pend_v = 1'b0; pend_bad = 1'b0; prev_bad = 1'b0; pend = 8'h00;
        exp_cmd = 16'h57F2; exp_rdy = 1'b1; exp_frm = frm_cnt;
        for (int e = 0; e < 16; e++) begin
            b = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            if (pend_v && pend_bad) good = 1'b1;
            long_gap = ($urandom_range(0, 3) == 0);
            if (long_gap) gap = TO + 100 + int'($urandom_range(0, 100));
            else gap = int'($urandom_range(0, 40)) + (prev_bad ? B : 0);
            if ($urandom_range(0, 3) == 0) begin
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                exp_rdy = 1'b0;
                if (gap > 0) gap--;
            end
            idle(gap);
            if (long_gap) begin
                pend_v = 1'b0;
                pend_bad = 1'b0;
            end
            uart_send(b, good);
            if (good) begin
                if (pend_v) begin
                    exp_cmd = {pend, b};
                    exp_rdy = 1'b1;
                    pend_v = 1'b0;
                    pend_bad = 1'b0;
                end else begin
                    pend = b;
                    pend_v = 1'b1;
                    exp_rdy = 1'b0;
                end
            end else begin
                exp_frm++;
                if (pend_v) pend_bad = 1'b1;
            end
            prev_bad = !good;
            idle(1);
            check("rand_cmd", cmd, exp_cmd);
            check("rand_rdy", cmd_rdy, exp_rdy);
        end
        check("rand_frm_count", frm_cnt, exp_frm);
        idle(TO + 100);

        // simultaneous RX and TX, clear coinciding with completion
        got = 1'b0;
        fork
            begin
                uart_send(8'h4B, 1'b1);
                uart_send(8'hF1, 1'b1);
            end
            tx_frame(8'hA5, 1'b0);
            begin
                idle(12 * B);
                clr_cmd_rdy = 1'b1;
                for (int n = 0; n < 12 * B && !got; n++) begin
                    @(negedge clk);
                    if (cmd_rdy === 1'b1) got = 1'b1;
                end
                clr_cmd_rdy = 1'b0;
            end
        join
        check("set_beats_clear", got, 1'b1);
        check("dual_cmd", cmd, 16'h4BF1);
        check("dual_rdy", cmd_rdy, 1'b1);

        // reset during the 5th data bit of a low byte
        idle(B);
        uart_send(8'h4B, 1'b1);
        resp = 8'h3C;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        b = 8'h0F;
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = b[4];
        repeat (B / 2) @(negedge clk);
        check("pre_rst_tx_busy", tx_busy, 1'b1);
        check("pre_rst_cmd", cmd, 16'h4BF1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_TX", TX, 1'b1);
        check("mid_rst_cmd", cmd, 16'h0000);
        check("mid_rst_rdy", cmd_rdy, 1'b0);
        check("mid_rst_busy", tx_busy, 1'b0);
        check("mid_rst_resp_sent", resp_sent, 1'b0);
        check("mid_rst_frm_err", frm_err, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (B / 2 - 3) @(negedge clk);
        for (int i = 5; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
        idle(2 * B);
        fr0 = frm_cnt;
        uart_send(8'h4B, 1'b1);
        uart_send(8'hF1, 1'b1);
        idle(2);
        check("post_rst_cmd", cmd, 16'h4BF1);
        check("post_rst_rdy", cmd_rdy, 1'b1);
        check("post_rst_no_frm", frm_cnt - fr0, 0);
        check("never_4b57", saw_4b57, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
